// File: rtl/bsm_operand_feeder.sv
// Operand front end for the bit-serial signed multiplier: takes a parallel A/B pair, streams it
// LSB-first with sign extension, then captures and holds the product until the consumer takes it.
module bsm_operand_feeder #(
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic [4:0]    wa_in,
   input  logic [4:0]    wb_in,
   output logic          start,
   output logic [4:0]    WA,
   output logic [4:0]    WB,
   output logic          bitAin,
   output logic          bitBin,
   input  logic [31:0]   O_in,
   input  logic          done_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   result,
   output logic          err
);

   localparam int unsigned WdW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StOut} state_e;

   state_e         state_q, state_d;
   logic [DW-1:0]  sa_q, sb_q;
   logic [4:0]     wa_q, wb_q, maxw_q, k_q;
   logic [WdW-1:0] wd_q;
   logic [31:0]    result_q;
   logic           err_q;

   logic width_bad, last_bit, wd_expired;

   // Sign-extend v from its own width w up to DW bits.
   function automatic logic [DW-1:0] sext(input logic [DW-1:0] v, input logic [4:0] w);
      logic          sgn;
      logic [DW-1:0] r;
      sgn = 1'b0;
      r   = '0;
      for (int i = 0; i < int'(DW); i++) begin
         if (i + 1 == int'(w)) sgn = v[i];
      end
      for (int i = 0; i < int'(DW); i++) begin
         r[i] = (i < int'(w)) ? v[i] : sgn;
      end
      return r;
   endfunction

   assign width_bad = (wa_in == 5'd0) || (wb_in == 5'd0) ||
                      (int'(wa_in) > int'(DW)) || (int'(wb_in) > int'(DW));
   assign last_bit   = (k_q == maxw_q - 5'd1);
   assign wd_expired = (wd_q == WdW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = width_bad ? StOut : StStart;
         StStart: state_d = StShift;
         StShift: if (last_bit) state_d = StWait;
         StWait:  if (done_in || wd_expired) state_d = StOut;
         StOut:   if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q     <= '0;
         sb_q     <= '0;
         wa_q     <= '0;
         wb_q     <= '0;
         maxw_q   <= '0;
         k_q      <= '0;
         wd_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  result_q <= '0;
                  err_q    <= width_bad;
                  if (!width_bad) begin
                     sa_q   <= sext(a_in, wa_in);
                     sb_q   <= sext(b_in, wb_in);
                     wa_q   <= wa_in;
                     wb_q   <= wb_in;
                     maxw_q <= (wa_in > wb_in) ? wa_in : wb_in;
                  end
               end
            end
            StStart: begin
               k_q  <= '0;
               wd_q <= '0;
            end
            StShift: begin
               sa_q <= $signed(sa_q) >>> 1;
               sb_q <= $signed(sb_q) >>> 1;
               k_q  <= k_q + 5'd1;
            end
            StWait: begin
               wd_q <= wd_q + 1'b1;
               if (done_in) begin
                  result_q <= O_in;
                  err_q    <= 1'b0;
               end else if (wd_expired) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign WA = wa_q;
   assign WB = wb_q;

   always_comb begin
      in_ready  = 1'b0;
      start     = 1'b0;
      bitAin    = 1'b0;
      bitBin    = 1'b0;
      out_valid = 1'b0;
      result    = '0;
      err       = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = ~rst;
         StStart: start = 1'b1;
         StShift: begin
            bitAin = sa_q[0];
            bitBin = sb_q[0];
         end
         StOut: begin
            out_valid = 1'b1;
            result    = result_q;
            err       = err_q;
         end
         default: ;
      endcase
   end

endmodule
